// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: N_CH independent LED channels, each run as OFF, ON, BLINK or PWM.
// A channel is set up with a single-cycle write. Its own period counter produces a
// "tick" every `period` clock cycles. In BLINK mode the LED toggles on every tick.
// In PWM mode the phase advances on every tick and the LED is on while phase < duty.
// Optional feature macro: LED_BURST_COUNT_EN adds cfg_count/done. With it, a BLINK
// channel stops after cfg_count toggles and raises done.
module led_pattern_ctrl #(
  parameter int  N_CH   = 4,
  parameter int  CNT_W  = 26,
  parameter int  DUTY_W = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
`ifdef LED_BURST_COUNT_EN
  input  logic [7:0]        cfg_count,
  output logic [N_CH-1:0]   done,
`endif
  output logic [N_CH-1:0]   led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);

  mode_e             mode_q   [N_CH];
  mode_e             mode_d   [N_CH];
  logic [CNT_W-1:0]  period_q [N_CH];
  logic [CNT_W-1:0]  period_d [N_CH];
  logic [DUTY_W-1:0] duty_q   [N_CH];
  logic [DUTY_W-1:0] duty_d   [N_CH];
  logic [CNT_W-1:0]  cnt_q    [N_CH];
  logic [CNT_W-1:0]  cnt_d    [N_CH];
  logic [DUTY_W-1:0] phase_q  [N_CH];
  logic [DUTY_W-1:0] phase_d  [N_CH];
  logic [N_CH-1:0]   led_q, led_d;
`ifdef LED_BURST_COUNT_EN
  logic [7:0]        count_q   [N_CH];
  logic [7:0]        count_d   [N_CH];
  logic [7:0]        toggles_q [N_CH];
  logic [7:0]        toggles_d [N_CH];
  logic [N_CH-1:0]   done_q, done_d;
`endif

  logic [N_CH-1:0]  sel;
  logic [CNT_W-1:0] cfg_period_eff;

  // A period of 0 is treated as 1, so every stored period is at least 1.
  assign cfg_period_eff = (cfg_period == '0) ? CNT_ONE : cfg_period;

  // Decode the write strobe per channel. An out-of-range cfg_ch matches no channel.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel[i] = cfg_wr && (int'(cfg_ch) == i);
    end
  end

  // Next-state logic for each channel: a write reloads it, otherwise its mode runs.
  always_comb begin
    led_d = led_q;
`ifdef LED_BURST_COUNT_EN
    done_d = done_q;
`endif
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      cnt_d[i]    = cnt_q[i];
      phase_d[i]  = phase_q[i];
`ifdef LED_BURST_COUNT_EN
      count_d[i]   = count_q[i];
      toggles_d[i] = toggles_q[i];
`endif
      if (sel[i]) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period_eff;
        duty_d[i]   = cfg_duty;
        cnt_d[i]    = '0;
        phase_d[i]  = '0;
        led_d[i]    = (cfg_mode == MODE_ON);
`ifdef LED_BURST_COUNT_EN
        count_d[i]   = cfg_count;
        toggles_d[i] = '0;
        done_d[i]    = 1'b0;
`endif
      end else begin
        case (mode_q[i])
          MODE_OFF: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b0;
          end
          MODE_ON: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b1;
          end
          MODE_BLINK: begin
            cnt_d[i] = (cnt_q[i] == period_q[i] - CNT_ONE) ? '0 : cnt_q[i] + CNT_ONE;
`ifdef LED_BURST_COUNT_EN
            if (done_q[i]) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == period_q[i] - CNT_ONE) begin
              // The final toggle of a burst always leaves the LED dark.
              if (count_q[i] != '0 && toggles_q[i] == count_q[i] - 8'd1) begin
                led_d[i]  = 1'b0;
                done_d[i] = 1'b1;
              end else begin
                led_d[i]     = ~led_q[i];
                toggles_d[i] = toggles_q[i] + 8'd1;
              end
            end
`else
            if (cnt_q[i] == period_q[i] - CNT_ONE) led_d[i] = ~led_q[i];
`endif
          end
          MODE_PWM: begin
            cnt_d[i] = (cnt_q[i] == period_q[i] - CNT_ONE) ? '0 : cnt_q[i] + CNT_ONE;
            if (cnt_q[i] == period_q[i] - CNT_ONE) begin
              phase_d[i] = phase_q[i] + DUTY_ONE;
              led_d[i]   = (phase_d[i] < duty_q[i]);
            end
          end
          default: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // State registers. Reset returns every channel to OFF with period 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel arrays are ordinary flops, not RAM, so they can and must be reset like any other register.
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= CNT_ONE;
        duty_q[i]   <= '0;
        cnt_q[i]    <= '0;
        phase_q[i]  <= '0;
`ifdef LED_BURST_COUNT_EN
        count_q[i]   <= '0;
        toggles_q[i] <= '0;
`endif
      end
      led_q <= '0;
`ifdef LED_BURST_COUNT_EN
      done_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every flop samples its _d value from before the edge.
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        cnt_q[i]    <= cnt_d[i];
        phase_q[i]  <= phase_d[i];
`ifdef LED_BURST_COUNT_EN
        count_q[i]   <= count_d[i];
        toggles_q[i] <= toggles_d[i];
`endif
      end
      led_q <= led_d;
`ifdef LED_BURST_COUNT_EN
      done_q <= done_d;
`endif
    end
  end

  assign led = led_q;
`ifdef LED_BURST_COUNT_EN
  assign done = done_q;
`endif

endmodule
